// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encoding,
// default latencies and the start-qualifying helper.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_calc.sv
// Combinational multiply/divide datapath. Produces {hi, lo} in one 64-bit
// word plus a divide-by-zero flag; the caller decides what to latch.
module ex_mdu_calc
  import ex_mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally
  assign a_neg   = (op_i == MD_DIV) && a_i[31];
  assign b_neg   = (op_i == MD_DIV) && b_i[31];
  assign a_mag   = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag   = b_neg ? (32'd0 - b_i) : b_i;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;

  always_comb begin
    result_o      = 64'd0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MD_MULT:  result_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      MD_MULTU: result_o = {32'd0, a_i} * {32'd0, b_i};
      MD_DIV, MD_DIVU: begin
        result_o[63:32] = a_neg ? (32'd0 - r_mag) : r_mag;
        result_o[31:0]  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        div_by_zero_o   = (b_i == 32'd0);
      end
      default: result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: architectural HI/LO with a busy countdown
// that models the multi-cycle latency seen by the hazard unit.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic [63:0]   calc_result;
  logic          calc_dz;
  mdu_state_e    state;

  ex_mdu_calc u_calc (
    .op_i          (md_op),
    .a_i           (src_a),
    .b_i           (src_b),
    .result_o      (calc_result),
    .div_by_zero_o (calc_dz)
  );

  assign state = (count_q != '0) ? ST_RUN : ST_IDLE;

  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state)
      ST_IDLE: begin
        if (start && is_md_start(md_op)) begin
          // A zero divisor re-latches the current HI/LO so completion leaves them unchanged
          {pend_hi_d, pend_lo_d} = calc_dz ? {hi_q, lo_q} : calc_result;
          count_d = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CW'(MULT_CYCLES)
                                                                 : CW'(DIV_CYCLES);
        end else if (md_op == MD_MTHI) begin
          hi_d = src_a;
        end else if (md_op == MD_MTLO) begin
          lo_d = src_a;
        end
      end
      ST_RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = (state == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
